rr_interval_meter: RTL and testbench
====================================

// Module: rr_interval_meter
// PURPOSE
//  Downstream of the QRS extremum detector. Consumes its one-cycle R-peak pulse and measures the
//  RR interval in sample ticks (i_ce). Rejects peaks that come too early, flags asystole timeouts,
//  and keeps a running mean of the last 2**AVG_LOG2 accepted intervals for the heart-rate stage.
// PARAMETERS
//  CNT_WIDTH  11   width of interval counter/outputs; must hold MAX_RR
//  AVG_LOG2   3    log2 of averaging window depth (8 intervals)
//  MIN_RR     72   shortest accepted interval, ticks (matches refractory window)
//  MAX_RR     720  timeout interval, ticks (2 s @ 360 Hz)
// PORTS
//  i_clk          in   1          clock
//  i_rst          in   1          synchronous, active-high reset
//  i_ce           in   1          sample tick, one cycle per input sample
//  i_extremum     in   1          R-peak pulse from extremum detector
//  o_rr_interval  out  CNT_WIDTH  last accepted interval, ticks
//  o_rr_valid     out  1          one-cycle pulse: o_rr_interval updated
//  o_rr_avg       out  CNT_WIDTH  mean of last 2**AVG_LOG2 accepted intervals
//  o_avg_valid    out  1          level: averaging window fully populated
//  o_timeout      out  1          one-cycle pulse: no peak within MAX_RR ticks
//  o_tracking     out  1          level: FSM in MEASURE
// BEHAVIOUR
//  Reset: all outputs 0, FSM->WAIT_FIRST, cnt=0, sum=0, buffer entries=0, wr_ptr=0, fill=0.
//  i_rst has priority over every other input, in any state and mid-measurement.
//  FSM WAIT_FIRST: ignore i_ce. On i_extremum go to MEASURE with cnt=0. No o_rr_valid.
//  FSM MEASURE: cnt_next = cnt + i_ce, saturating at MAX_RR.
//   - i_extremum and cnt_next < MIN_RR: reject as artifact. cnt keeps counting. No output.
//   - i_extremum and cnt_next >= MIN_RR: accept. Then:
//       o_rr_interval <= cnt_next; o_rr_valid pulses next cycle; cnt <= 0; stay in MEASURE.
//   - no i_extremum and cnt_next == MAX_RR: o_timeout pulses next cycle; go to WAIT_FIRST.
//       The timeout also clears sum, buffer, fill and o_avg_valid. o_rr_interval is held.
//   - Extremum in the same cycle cnt_next reaches MAX_RR: accept with interval MAX_RR; no timeout.
//  Latency: o_rr_valid and o_timeout are registered, 1 cycle after the causing i_extremum/i_ce.
//  i_ce and i_extremum in the same cycle: the tick counts first, so the interval includes it.
//  Averager: circular buffer of 2**AVG_LOG2 entries x CNT_WIDTH, sum width CNT_WIDTH+AVG_LOG2.
//   - On accept: sum <= sum - buf[wr_ptr] + interval; buf[wr_ptr] <= interval.
//   - wr_ptr wraps modulo depth. fill saturates at depth.
//   - o_rr_avg = sum >> AVG_LOG2 (truncating), registered. It updates in the same cycle as
//     o_rr_valid and is 0 after reset/timeout.
//   - o_avg_valid rises in the o_rr_valid cycle of the 2**AVG_LOG2-th accepted interval since
//     reset/timeout. It stays high until reset/timeout.
//  o_tracking = (state == MEASURE), registered. It is 0 in the cycle o_timeout pulses.
//  All arithmetic is unsigned. Sum cannot overflow by construction.
// TESTING
//  1. Reset, one extremum -> o_tracking=1 next cycle, no o_rr_valid, o_rr_avg=0.
//  2. Peaks every 300 ticks x9 -> 8 pulses of o_rr_valid with o_rr_interval=300.
//     o_avg_valid rises on the 8th pulse with o_rr_avg=300.
//  3. Peak 50 ticks after an accepted peak, next peak 250 ticks later -> the 50-tick peak
//     is ignored; one o_rr_valid with interval 300.
//  4. After steady 300s, no peak for 720 ticks -> o_timeout pulses once, o_avg_valid=0,
//     o_rr_avg=0, o_tracking=0. The next peak produces no o_rr_valid.
//  5. Peak coincident with the 720th tick -> o_rr_valid with interval 720, no o_timeout.
//  6. i_rst asserted mid-interval (cnt=150) -> all outputs 0 next cycle; back to WAIT_FIRST.
//  7. Intervals 200,400 alternating (AVG_LOG2=3) -> o_rr_avg=300 once the window is full.

Source files
------------

// File: rtl/rr_interval_meter.sv
// RR interval meter: measures the tick count between accepted R-peaks, rejects early
// artifacts, flags asystole timeouts and keeps a running mean over the last 2**AVG_LOG2 intervals.
`timescale 1ns/1ps
module rr_interval_meter #(
    parameter int CNT_WIDTH = 11,
    parameter int AVG_LOG2  = 3,
    parameter int MIN_RR    = 72,
    parameter int MAX_RR    = 720
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic                 i_extremum,
    output logic [CNT_WIDTH-1:0] o_rr_interval,
    output logic                 o_rr_valid,
    output logic [CNT_WIDTH-1:0] o_rr_avg,
    output logic                 o_avg_valid,
    output logic                 o_timeout,
    output logic                 o_tracking
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = CNT_WIDTH + AVG_LOG2;
    localparam logic [CNT_WIDTH-1:0] MIN_V  = CNT_WIDTH'(MIN_RR);
    localparam logic [CNT_WIDTH-1:0] MAX_V  = CNT_WIDTH'(MAX_RR);
    localparam logic [AVG_LOG2:0]    FULL_V = (AVG_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_next;
    logic [CNT_WIDTH-1:0] rr_buf [DEPTH];
    logic [AVG_LOG2-1:0]  wr_ptr;
    logic [AVG_LOG2:0]    fill;
    logic                 accept;
    logic                 expire;

    function automatic logic [CNT_WIDTH-1:0] sat_tick(input logic [CNT_WIDTH-1:0] a,
                                                      input logic inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{CNT_WIDTH{1'b0}}, inc};
        return (s >= {1'b0, MAX_V}) ? MAX_V : s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] trunc_avg(input logic [SUM_W-1:0] s);
        return CNT_WIDTH'(s >> AVG_LOG2);
    endfunction

    // The tick in the peak cycle is counted before the accept/timeout decision.
    always_comb begin
        cnt_next = sat_tick(cnt, i_ce);
        accept   = (state == MEASURE) && i_extremum && (cnt_next >= MIN_V);
        expire   = (state == MEASURE) && !i_extremum && (cnt_next == MAX_V);
        sum_next = sum - SUM_W'(rr_buf[wr_ptr]) + SUM_W'(cnt_next);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= WAIT_FIRST;
            cnt           <= '0;
            sum           <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            for (int i = 0; i < DEPTH; i++) rr_buf[i] <= '0;
            o_rr_interval <= '0;
            o_rr_valid    <= 1'b0;
            o_rr_avg      <= '0;
            o_avg_valid   <= 1'b0;
            o_timeout     <= 1'b0;
            o_tracking    <= 1'b0;
        end else begin
            o_rr_valid <= 1'b0;
            o_timeout  <= 1'b0;
            if (state == WAIT_FIRST) begin
                if (i_extremum) begin
                    state      <= MEASURE;
                    cnt        <= '0;
                    o_tracking <= 1'b1;
                end
            end else if (accept) begin
                cnt             <= '0;
                o_rr_interval   <= cnt_next;
                o_rr_valid      <= 1'b1;
                sum             <= sum_next;
                rr_buf[wr_ptr]  <= cnt_next;
                wr_ptr          <= wr_ptr + 1'b1;
                o_rr_avg        <= trunc_avg(sum_next);
                if (fill != FULL_V) fill <= fill + 1'b1;
                o_avg_valid     <= o_avg_valid | (fill == FULL_V - 1'b1);
            end else if (expire) begin
                // Asystole: restart acquisition and drop the stale averaging history.
                state       <= WAIT_FIRST;
                cnt         <= '0;
                sum         <= '0;
                wr_ptr      <= '0;
                fill        <= '0;
                for (int i = 0; i < DEPTH; i++) rr_buf[i] <= '0;
                o_rr_avg    <= '0;
                o_avg_valid <= 1'b0;
                o_timeout   <= 1'b1;
                o_tracking  <= 1'b0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_rr_interval_meter.sv
// Bench for rr_interval_meter: directed scenarios with constant expectations, then a
// randomized run checked every cycle against a queue-based model of the interval rules.
`timescale 1ns/1ps
module tb_rr_interval_meter;

    localparam int MIN_RR = 72;
    localparam int MAX_RR = 720;
    localparam int DEPTH  = 8;

    logic        i_clk;
    logic        i_rst;
    logic        i_ce;
    logic        i_extremum;
    logic [10:0] o_rr_interval;
    logic        o_rr_valid;
    logic [10:0] o_rr_avg;
    logic        o_avg_valid;
    logic        o_timeout;
    logic        o_tracking;

    rr_interval_meter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ce         (i_ce),
        .i_extremum   (i_extremum),
        .o_rr_interval(o_rr_interval),
        .o_rr_valid   (o_rr_valid),
        .o_rr_avg     (o_rr_avg),
        .o_avg_valid  (o_avg_valid),
        .o_timeout    (o_timeout),
        .o_tracking   (o_tracking)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time since last anchor peak plus a history of accepted intervals.
    bit  m_track;
    int  m_ticks;
    int  m_hist[$];
    int  e_int, e_avg;
    bit  e_valid, e_avgv, e_to, e_track;

    task automatic model_update(input bit rst, input bit ce, input bit ext);
        int t;
        int s;
        e_valid = 0;
        e_to    = 0;
        if (rst) begin
            m_track = 0; m_ticks = 0; m_hist.delete();
            e_int = 0; e_avg = 0; e_avgv = 0;
        end else if (!m_track) begin
            if (ext) begin m_track = 1; m_ticks = 0; end
        end else begin
            t = m_ticks + (ce ? 1 : 0);
            if (t > MAX_RR) t = MAX_RR;
            if (ext && t >= MIN_RR) begin
                e_valid = 1; e_int = t; m_ticks = 0;
                m_hist.push_back(t);
                if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
                s = 0;
                foreach (m_hist[i]) s += m_hist[i];
                e_avg  = s / DEPTH;
                e_avgv = (m_hist.size() == DEPTH);
            end else if (!ext && t == MAX_RR) begin
                e_to = 1; m_track = 0; m_ticks = 0; m_hist.delete();
                e_avg = 0; e_avgv = 0;
            end else begin
                m_ticks = t;
            end
        end
        e_track = m_track;
    endtask

    task automatic step(input logic ce, input logic ext);
        i_ce = ce;
        i_extremum = ext;
        @(posedge i_clk);
        model_update(i_rst, ce, ext);
        #1;
        i_ce = 1'b0;
        i_extremum = 1'b0;
    endtask

    // Issues exactly `ticks` sample ticks with random idle cycles; counts any output pulses seen.
    task automatic gap(input int ticks, output int pulses);
        int n;
        n = 0;
        pulses = 0;
        while (n < ticks) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
            else begin step(1'b1, 1'b0); n++; end
            if (o_rr_valid || o_timeout) pulses++;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(1'b0, 1'b0);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        i_rst = 1'b0;
        n_checks++; if (o_rr_interval !== 11'd0) $display("FAIL reset_interval: got %0d want 0", o_rr_interval); else n_pass++;
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_rr_avg !== 11'd0) $display("FAIL reset_avg: got %0d want 0", o_rr_avg); else n_pass++;
        n_checks++; if (o_avg_valid !== 1'b0) $display("FAIL reset_avg_valid: got %b want 0", o_avg_valid); else n_pass++;
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", o_timeout); else n_pass++;
        n_checks++; if (o_tracking !== 1'b0) $display("FAIL reset_tracking: got %b want 0", o_tracking); else n_pass++;
        step(1'b1, 1'b1);
        n_checks++; if (o_tracking !== 1'b1) $display("FAIL first_peak_tracking: got %b want 1", o_tracking); else n_pass++;
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL first_peak_valid: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_rr_avg !== 11'd0) $display("FAIL first_peak_avg: got %0d want 0", o_rr_avg); else n_pass++;
    endtask

    task automatic test_steady();
        int p;
        do_reset();
        step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            gap(299, p);
            n_checks++; if (p !== 0) $display("FAIL steady_gap_pulses[%0d]: got %0d want 0", k, p); else n_pass++;
            step(1'b1, 1'b1);
            n_checks++; if (o_rr_valid !== 1'b1) $display("FAIL steady_valid[%0d]: got %b want 1", k, o_rr_valid); else n_pass++;
            n_checks++; if (o_rr_interval !== 11'd300) $display("FAIL steady_interval[%0d]: got %0d want 300", k, o_rr_interval); else n_pass++;
            n_checks++; if (o_rr_avg !== 11'((300 * (k + 1)) / 8)) $display("FAIL steady_avg[%0d]: got %0d want %0d", k, o_rr_avg, (300 * (k + 1)) / 8); else n_pass++;
            n_checks++; if (o_avg_valid !== (k == 7)) $display("FAIL steady_avg_valid[%0d]: got %b want %b", k, o_avg_valid, k == 7); else n_pass++;
        end
        step(1'b0, 1'b0);
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL steady_valid_pulse: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_avg_valid !== 1'b1) $display("FAIL steady_avg_valid_hold: got %b want 1", o_avg_valid); else n_pass++;
    endtask

    task automatic test_reject();
        int p;
        do_reset();
        step(1'b0, 1'b1);
        gap(299, p);
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_interval !== 11'd300) $display("FAIL reject_first: got %0d want 300", o_rr_interval); else n_pass++;
        gap(49, p);
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL reject_early_valid: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_tracking !== 1'b1) $display("FAIL reject_tracking: got %b want 1", o_tracking); else n_pass++;
        gap(249, p);
        n_checks++; if (p !== 0) $display("FAIL reject_gap_pulses: got %0d want 0", p); else n_pass++;
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_valid !== 1'b1) $display("FAIL reject_next_valid: got %b want 1", o_rr_valid); else n_pass++;
        n_checks++; if (o_rr_interval !== 11'd300) $display("FAIL reject_next_interval: got %0d want 300", o_rr_interval); else n_pass++;
    endtask

    task automatic test_timeout();
        int p;
        do_reset();
        step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin gap(299, p); step(1'b1, 1'b1); end
        n_checks++; if (o_avg_valid !== 1'b1) $display("FAIL timeout_pre_avg_valid: got %b want 1", o_avg_valid); else n_pass++;
        gap(719, p);
        n_checks++; if (p !== 0) $display("FAIL timeout_gap_pulses: got %0d want 0", p); else n_pass++;
        step(1'b1, 1'b0);
        n_checks++; if (o_timeout !== 1'b1) $display("FAIL timeout_pulse: got %b want 1", o_timeout); else n_pass++;
        n_checks++; if (o_avg_valid !== 1'b0) $display("FAIL timeout_avg_valid: got %b want 0", o_avg_valid); else n_pass++;
        n_checks++; if (o_rr_avg !== 11'd0) $display("FAIL timeout_avg: got %0d want 0", o_rr_avg); else n_pass++;
        n_checks++; if (o_tracking !== 1'b0) $display("FAIL timeout_tracking: got %b want 0", o_tracking); else n_pass++;
        n_checks++; if (o_rr_interval !== 11'd300) $display("FAIL timeout_interval_held: got %0d want 300", o_rr_interval); else n_pass++;
        step(1'b0, 1'b0);
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL timeout_single: got %b want 0", o_timeout); else n_pass++;
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL timeout_next_peak_valid: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_tracking !== 1'b1) $display("FAIL timeout_next_peak_tracking: got %b want 1", o_tracking); else n_pass++;
        gap(299, p);
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_avg !== 11'd37) $display("FAIL timeout_history_cleared: got %0d want 37", o_rr_avg); else n_pass++;
        n_checks++; if (o_avg_valid !== 1'b0) $display("FAIL timeout_refill_avg_valid: got %b want 0", o_avg_valid); else n_pass++;
    endtask

    task automatic test_max_coincident();
        int p;
        do_reset();
        step(1'b0, 1'b1);
        gap(719, p);
        step(1'b1, 1'b1);
        n_checks++; if (o_rr_valid !== 1'b1) $display("FAIL max_valid: got %b want 1", o_rr_valid); else n_pass++;
        n_checks++; if (o_rr_interval !== 11'd720) $display("FAIL max_interval: got %0d want 720", o_rr_interval); else n_pass++;
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL max_timeout: got %b want 0", o_timeout); else n_pass++;
        step(1'b0, 1'b0);
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL max_timeout_late: got %b want 0", o_timeout); else n_pass++;
        n_checks++; if (o_tracking !== 1'b1) $display("FAIL max_tracking: got %b want 1", o_tracking); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int p;
        do_reset();
        step(1'b0, 1'b1);
        gap(299, p);
        step(1'b1, 1'b1);
        gap(150, p);
        i_rst = 1'b1;
        step(1'b1, 1'b1);
        i_rst = 1'b0;
        n_checks++; if (o_rr_interval !== 11'd0) $display("FAIL midrst_interval: got %0d want 0", o_rr_interval); else n_pass++;
        n_checks++; if (o_rr_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_rr_valid); else n_pass++;
        n_checks++; if (o_rr_avg !== 11'd0) $display("FAIL midrst_avg: got %0d want 0", o_rr_avg); else n_pass++;
        n_checks++; if (o_tracking !== 1'b0) $display("FAIL midrst_tracking: got %b want 0", o_tracking); else n_pass++;
        gap(400, p);
        n_checks++; if (p !== 0) $display("FAIL midrst_idle_pulses: got %0d want 0", p); else n_pass++;
        n_checks++; if (o_tracking !== 1'b0) $display("FAIL midrst_wait_first: got %b want 0", o_tracking); else n_pass++;
    endtask

    task automatic test_alternating();
        int p;
        int len;
        do_reset();
        step(1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            len = (k % 2 == 0) ? 200 : 400;
            gap(len - 1, p);
            step(1'b1, 1'b1);
            n_checks++; if (o_rr_interval !== 11'(len)) $display("FAIL alt_interval[%0d]: got %0d want %0d", k, o_rr_interval, len); else n_pass++;
            n_checks++; if (o_avg_valid !== (k >= 7)) $display("FAIL alt_avg_valid[%0d]: got %b want %b", k, o_avg_valid, k >= 7); else n_pass++;
            if (k >= 7) begin
                n_checks++; if (o_rr_avg !== 11'd300) $display("FAIL alt_avg[%0d]: got %0d want 300", k, o_rr_avg); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic ce, ext;
        int lim;
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            lim = ((c / 1500) % 2 == 1) ? 1500 : 110;
            ce  = ($urandom_range(0, 3) != 0);
            ext = ($urandom_range(0, lim - 1) == 0);
            i_rst = ($urandom_range(0, 2499) == 0);
            step(ce, ext);
            i_rst = 1'b0;
            n_checks++; if (o_rr_valid !== e_valid) $display("FAIL rnd_valid@%0d: got %b want %b", c, o_rr_valid, e_valid); else n_pass++;
            n_checks++; if (o_rr_interval !== 11'(e_int)) $display("FAIL rnd_interval@%0d: got %0d want %0d", c, o_rr_interval, e_int); else n_pass++;
            n_checks++; if (o_rr_avg !== 11'(e_avg)) $display("FAIL rnd_avg@%0d: got %0d want %0d", c, o_rr_avg, e_avg); else n_pass++;
            n_checks++; if (o_avg_valid !== e_avgv) $display("FAIL rnd_avg_valid@%0d: got %b want %b", c, o_avg_valid, e_avgv); else n_pass++;
            n_checks++; if (o_timeout !== e_to) $display("FAIL rnd_timeout@%0d: got %b want %b", c, o_timeout, e_to); else n_pass++;
            n_checks++; if (o_tracking !== e_track) $display("FAIL rnd_tracking@%0d: got %b want %b", c, o_tracking, e_track); else n_pass++;
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_ce       = 1'b0;
        i_extremum = 1'b0;
        test_reset();
        test_steady();
        test_reject();
        test_timeout();
        test_max_coincident();
        test_mid_reset();
        test_alternating();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
